// File: rtl/riscv_pkg.sv
// Shared RV32 types: data word, memory op encoding, access-fault flags
// and the byte-enable / store-data helpers used by the memory stage.
package riscv;

    typedef logic [31:0] data_t;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    localparam logic FAULT_NONE   = 1'b0;
    localparam logic FAULT_ACCESS = 1'b1;

    function automatic logic is_load(mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic misaligned(mem_op_t op, logic [1:0] off);
        logic half;
        logic word;
        half = op inside {MEM_LH, MEM_LHU, MEM_SH};
        word = op inside {MEM_LW, MEM_SW};
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

    function automatic logic [3:0] store_be(mem_op_t op, logic [1:0] off);
        case (op)
            MEM_SB:  return 4'b0001 << off;
            MEM_SH:  return off[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Narrow stores replicate across lanes so be alone selects the bytes.
    function automatic data_t store_wdata(mem_op_t op, data_t wd);
        case (op)
            MEM_SB:  return {4{wd[7:0]}};
            MEM_SH:  return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load lane extraction: picks the byte/half lane by
// address offset and sign- or zero-extends according to the op.
module load_align
    import riscv::*;
(
    input  mem_op_t    op,
    input  logic [1:0] offset,
    input  data_t      rdata,
    output data_t      data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[8*offset +: 8];
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        data   = '0;
        case (op)
            MEM_LB:  data = {{24{lane_b[7]}}, lane_b};
            MEM_LBU: data = {24'd0, lane_b};
            MEM_LH:  data = {{16{lane_h[15]}}, lane_h};
            MEM_LHU: data = {16'd0, lane_h};
            MEM_LW:  data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage: one load/store in flight over a req/gnt/rvalid bus.
// Define MISALIGNED_TRAP_EN to fault misaligned half/word accesses.
module memory_access
    import riscv::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  mem_op_t     op,
    input  data_t       addr,
    input  data_t       wdata,
    input  logic [4:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    mem_op_t       op_q;
    data_t         addr_q;
    data_t         wdata_q;
    logic [4:0]    rd_q;
    data_t         data_q, data_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          take;
    logic          trap;
    data_t         load_data;

`ifdef MISALIGNED_TRAP_EN
    assign trap = misaligned(op, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    load_align u_align (
        .op     (op_q),
        .offset (addr_q[1:0]),
        .rdata  (dmem_rdata),
        .data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    take = 1'b1;
                    if (op == MEM_NONE) begin
                        data_d  = addr;
                        fault_d = FAULT_NONE;
                        state_d = S_DONE;
                    end else if (trap) begin
                        data_d  = '0;
                        fault_d = FAULT_ACCESS;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt) begin
                    if (is_store(op_q)) begin
                        data_d  = '0;
                        fault_d = FAULT_NONE;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response on the last allowed cycle still wins.
                if (dmem_rvalid) begin
                    data_d  = load_data;
                    fault_d = FAULT_NONE;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    fault_d = FAULT_ACCESS;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= MEM_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            fault_q <= FAULT_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            if (take) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                rd_q    <= rd;
            end
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_data   = data_q;
    assign out_rd     = rd_q;
    assign out_fault  = fault_q;

    // Bus fields come straight from the captured op, so they hold until gnt.
    assign dmem_req   = (state_q == S_REQ);
    assign dmem_we    = dmem_req && is_store(op_q);
    assign dmem_be    = !dmem_req        ? 4'b0000 :
                        is_store(op_q)   ? store_be(op_q, addr_q[1:0]) :
                                           4'b1111;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wdata = store_wdata(op_q, wdata_q);

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the max cycles waiting for dmem_rvalid before a load faults.
REQ-002 clk  in  1  rising-edge clock, sole clock domain.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1; in_ready  out  1  upstream handshake from execute.
REQ-005 op  in  mem_op_t(4)  NONE/LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-006 addr  in  data_t(32)  effective address = execute alu result.
REQ-007 wdata  in  data_t(32)  store data (rs2).
REQ-008 rd  in  5  destination register, passed through.
REQ-009 out_valid  out  1; out_ready  in  1  downstream handshake to writeback.
REQ-010 out_data  out  32; out_rd  out  5; out_fault  out  1  result, dest, access fault.
REQ-011 dmem_req  out  1; dmem_we  out  1; dmem_be  out  4; dmem_addr  out  32 (bits[1:0]=0); dmem_wdata  out  32  data bus request.
REQ-012 dmem_gnt  in  1; dmem_rvalid  in  1; dmem_rdata  in  32  bus grant and read response.

Function
REQ-013 FSM states IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Transfer SHALL occur when in_valid&in_ready; op/addr/wdata/rd captured into registers that cycle.
REQ-015 IDLE->DONE on accept of op NONE; out_data=addr, out_valid next cycle (latency 1).
REQ-016 IDLE->REQ on accept of load/store; dmem_req=1 from next cycle, all dmem_* outputs stable until dmem_gnt.
REQ-017 REQ->DONE on dmem_gnt for stores; REQ->WAIT on dmem_gnt for loads; dmem_req drops the cycle after gnt.
REQ-018 WAIT->DONE on dmem_rvalid; out_data = extracted lane: LB/LH sign-extended, LBU/LHU zero-extended, LW whole word; lane chosen by addr[1:0].
REQ-019 Stores: dmem_be SB=0001<<addr[1:0], SH=0011<<{addr[1],0}, SW=1111; dmem_wdata replicates byte/half across lanes; out_data=0.
REQ-020 WAIT counter SHALL reset on WAIT entry; reaching TIMEOUT without rvalid -> DONE with out_fault=1, out_data=0.
REQ-021 dmem_rvalid outside WAIT SHALL be ignored.
REQ-022 DONE holds out_valid and all out_* until out_ready; DONE->IDLE on out_ready.
REQ-023 rvalid and timeout in same cycle: rvalid wins, no fault.

Reset
REQ-024 rst SHALL force IDLE, in_ready=1, out_valid=0, out_fault=0, out_data=0, out_rd=0, dmem_req=0, dmem_we=0, dmem_be=0, counter=0.
REQ-025 rst mid-transaction SHALL abandon it; no dmem_req in the cycle after rst deasserts.

Configuration
REQ-026 With MISALIGNED_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL go IDLE->DONE with out_fault=1, no dmem_req.
REQ-027 Without MISALIGNED_TRAP_EN: low address bits below access size SHALL be ignored (halves use addr[1], words aligned); out_fault only from timeout.

Structure
REQ-028 mem_op_t and fault constants SHALL live in package riscv alongside data_t.
REQ-029 Lane extraction/sign-extension SHALL be sub-module load_align (combinational).

Verification
REQ-030 NONE, addr=0x1234 -> out_valid one cycle later, out_data=0x1234, dmem_req never asserted.
REQ-031 LB addr=0x103, rdata=0x80FF_0000 (gnt after 2 cycles, rvalid 1 later) -> out_data=0xFFFF_FF80, rd passed.
REQ-032 SH addr=0x202, wdata=0xABCD -> dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD, we=1.
REQ-033 LW, no rvalid for 16 cycles -> out_fault=1, out_data=0, return to IDLE after out_ready.
REQ-034 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0 throughout.
REQ-035 MISALIGNED_TRAP_EN, LW addr=0x101 -> out_fault=1 at latency 1, no dmem_req; without macro -> dmem_addr=0x100.
